// File: rtl/packed_bank_reduce_if.sv
// Bus bundle for packed_bank_reduce: lane writes, scan handshake, result and reduction outputs.
interface packed_bank_reduce_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(LANES);
  localparam int SW = WIDTH + LW;

  logic                   wr_en;
  logic [LW-1:0]          wr_lane;
  logic [WIDTH-1:0]       wr_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [SW-1:0]          sum;
  logic                   sat;
  logic [LANES*WIDTH-1:0] bank;
  logic                   red_or;
  logic                   red_and;
  logic                   red_xor;
  logic                   red_xnor;

  modport master (
    output wr_en, wr_lane, wr_data, start,
    input  busy, done, sum, sat, bank, red_or, red_and, red_xor, red_xnor
  );

  modport slave (
    input  wr_en, wr_lane, wr_data, start,
    output busy, done, sum, sat, bank, red_or, red_and, red_xor, red_xnor
  );
endinterface

// File: rtl/packed_bank_reduce.sv
// Packed lane bank with registered bit reductions and a sequential lane-sum scan.
// Optional saturating summation is selected by macro PACKED_BANK_REDUCE_SAT_EN.
module packed_bank_reduce #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  packed_bank_reduce_if.slave  bus
);
  localparam int LW = $clog2(LANES);
  localparam int SW = WIDTH + LW;
  localparam logic [SW-1:0] CLAMP = {{LW{1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0]  bank_q;
  logic [LW-1:0]                idx_q;
  logic [SW-1:0]                acc_q, sum_q, add_full, acc_next;
  logic                         sat_q, sat_acc_q, ovf, last_lane;
  logic                         red_or_q, red_and_q, red_xor_q;

  assign last_lane = (idx_q == LW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (last_lane) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_full = acc_q + SW'(bank_q[idx_q]);
`ifdef PACKED_BANK_REDUCE_SAT_EN
    ovf      = (add_full > CLAMP);
    acc_next = ovf ? CLAMP : add_full;
`else
    ovf      = 1'b0;
    acc_next = add_full;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      sat_acc_q <= 1'b0;
      red_or_q  <= 1'b0;
      red_and_q <= 1'b0;
      red_xor_q <= 1'b0;
    end else begin
      // out-of-range lane indices only exist when LANES is not a power of two
      if (bus.wr_en && ({1'b0, bus.wr_lane} < (LW + 1)'(LANES)))
        bank_q[bus.wr_lane] <= bus.wr_data;
      red_or_q  <= |bank_q;
      red_and_q <= &bank_q;
      red_xor_q <= ^bank_q;
      case (state_q)
        IDLE: if (bus.start) begin
          idx_q     <= '0;
          acc_q     <= '0;
          sat_acc_q <= 1'b0;
        end
        SCAN: begin
          acc_q     <= acc_next;
          idx_q     <= idx_q + 1'b1;
          sat_acc_q <= sat_acc_q | ovf;
          if (last_lane) begin
            sum_q <= acc_next;
            sat_q <= sat_acc_q | ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.sat      = sat_q;
  assign bus.bank     = bank_q;
  assign bus.red_or   = red_or_q;
  assign bus.red_and  = red_and_q;
  assign bus.red_xor  = red_xor_q;
  assign bus.red_xnor = ~red_xor_q;
endmodule

// File: tb/tb_packed_bank_reduce.sv
// Directed self-checking bench for packed_bank_reduce (LANES=4 and LANES=3 instances, WIDTH=8).
module tb_packed_bank_reduce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  packed_bank_reduce_if #(.LANES(4), .WIDTH(8)) bus4 ();
  packed_bank_reduce_if #(.LANES(3), .WIDTH(8)) bus3 ();

  packed_bank_reduce #(.LANES(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  packed_bank_reduce #(.LANES(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write4(input int lane, input logic [7:0] d);
    bus4.wr_en = 1'b1; bus4.wr_lane = 2'(lane); bus4.wr_data = d;
    step();
    bus4.wr_en = 1'b0;
  endtask

  task automatic write3(input int lane, input logic [7:0] d);
    bus3.wr_en = 1'b1; bus3.wr_lane = 2'(lane); bus3.wr_data = d;
    step();
    bus3.wr_en = 1'b0;
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    write4(0, a); write4(1, b); write4(2, c); write4(3, d);
  endtask

  // Pulses start in the current cycle T, then walks T+1..T+5 checking busy/done; ends in T+5.
  task automatic scan4(input string name);
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (bus4.done !== (k == 5) || bus4.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle T+%0d: done=%b busy=%b, required done=%b busy=1", name, k, bus4.done, bus4.busy, (k == 5));
      end
      if (k < 5) step();
    end
  endtask

  task automatic test_reset();
    bus4.wr_en = 0; bus4.wr_lane = 0; bus4.wr_data = 0; bus4.start = 0;
    bus3.wr_en = 0; bus3.wr_lane = 0; bus3.wr_data = 0; bus3.start = 0;
    rst = 1'b1;
    // write and start with rst high must be overridden by reset
    bus4.wr_en = 1'b1; bus4.wr_data = 8'hAA; bus4.start = 1'b1;
    step(); step();
    bus4.wr_en = 1'b0; bus4.start = 1'b0;
    rst = 1'b0;
    checks++;
    if (bus4.bank !== 32'h0 || bus4.sum !== 10'h0 || bus4.sat !== 1'b0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bank=%h sum=%h sat=%b busy=%b done=%b, required all zero", bus4.bank, bus4.sum, bus4.sat, bus4.busy, bus4.done);
    end
    checks++;
    if ({bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_red: or/and/xor/xnor=%b, required 0001", {bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor});
    end
  endtask

  task automatic test_reductions();
    step();
    checks++;
    if ({bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor} !== 4'b0001) begin
      errors++;
      $display("FAIL red_zero: or/and/xor/xnor=%b, required 0001", {bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor});
    end
    write4(0, 8'h01);
    checks++;
    if (bus4.bank !== 32'h0000_0001) begin
      errors++;
      $display("FAIL bank_write: bank=%h, required 00000001", bus4.bank);
    end
    step();
    checks++;
    if ({bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor} !== 4'b1010) begin
      errors++;
      $display("FAIL red_one: or/and/xor/xnor=%b, required 1010", {bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor});
    end
    load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    step();
    checks++;
    if ({bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor} !== 4'b1101) begin
      errors++;
      $display("FAIL red_ones: or/and/xor/xnor=%b, required 1101", {bus4.red_or, bus4.red_and, bus4.red_xor, bus4.red_xnor});
    end
  endtask

  task automatic test_basic_scan();
    load4(8'h01, 8'h04, 8'h10, 8'h40);
    scan4("basic");
    checks++;
    if (bus4.sum !== 10'h055 || bus4.sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: sum=%h sat=%b, required 055 0", bus4.sum, bus4.sat);
    end
    step();
    checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.sum !== 10'h055) begin
      errors++;
      $display("FAIL basic_after: busy=%b done=%b sum=%h, required 0 0 055", bus4.busy, bus4.done, bus4.sum);
    end
  endtask

  task automatic test_write_during_scan();
    load4(8'h01, 8'h04, 8'h10, 8'h40);
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    bus4.wr_en = 1'b1; bus4.wr_lane = 2'd0; bus4.wr_data = 8'h80;
    step();
    bus4.wr_lane = 2'd3; bus4.wr_data = 8'h00;
    step();
    bus4.wr_en = 1'b0;
    step(); step();
    checks++;
    if (bus4.done !== 1'b1 || bus4.sum !== 10'h015) begin
      errors++;
      $display("FAIL wr_scan_sum: done=%b sum=%h, required 1 015", bus4.done, bus4.sum);
    end
    step();
    checks++;
    if (bus4.bank !== 32'h0010_0480) begin
      errors++;
      $display("FAIL wr_scan_bank: bank=%h, required 00100480", bus4.bank);
    end
  endtask

  task automatic test_overflow();
    load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    scan4("overflow");
    checks++;
`ifdef PACKED_BANK_REDUCE_SAT_EN
    if (bus4.sum !== 10'h0FF || bus4.sat !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sum: sum=%h sat=%b, required 0ff 1", bus4.sum, bus4.sat);
    end
`else
    if (bus4.sum !== 10'h3FC || bus4.sat !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sum: sum=%h sat=%b, required 3fc 0", bus4.sum, bus4.sat);
    end
`endif
    step();
  endtask

  task automatic test_reset_mid_scan();
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done cycle %0d: done=%b busy=%b, required 0 0", k, bus4.done, bus4.busy);
      end
      step();
    end
    checks++;
    if (bus4.sum !== 10'h0 || bus4.bank !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: sum=%h bank=%h, required 0 0", bus4.sum, bus4.bank);
    end
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    scan4("rescan");
    checks++;
    if (bus4.sum !== 10'h00A) begin
      errors++;
      $display("FAIL rescan_sum: sum=%h, required 00a", bus4.sum);
    end
    step();
  endtask

  task automatic test_back_to_back();
    load4(8'h05, 8'h06, 8'h07, 8'h08);
    bus4.start = 1'b1;
    step();
    for (int k = 1; k <= 18; k++) begin
      checks++;
      if (bus4.done !== (k % 6 == 5) || bus4.busy !== (k % 6 != 0)) begin
        errors++;
        $display("FAIL b2b cycle T+%0d: done=%b busy=%b, required done=%b busy=%b", k, bus4.done, bus4.busy, (k % 6 == 5), (k % 6 != 0));
      end
      if (k == 5) begin
        checks++;
        if (bus4.sum !== 10'h01A) begin
          errors++;
          $display("FAIL b2b_sum: sum=%h, required 01a", bus4.sum);
        end
      end
      step();
    end
    bus4.start = 1'b0;
    step(); step(); step(); step(); step(); step();
  endtask

  task automatic test_lanes3();
    write3(0, 8'h10); write3(1, 8'h20); write3(2, 8'h30);
    write3(3, 8'hAA);
    checks++;
    if (bus3.bank !== 24'h302010) begin
      errors++;
      $display("FAIL l3_ignored_write: bank=%h, required 302010", bus3.bank);
    end
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus3.done !== (k == 4) || bus3.busy !== 1'b1) begin
        errors++;
        $display("FAIL l3_scan cycle T+%0d: done=%b busy=%b, required done=%b busy=1", k, bus3.done, bus3.busy, (k == 4));
      end
      if (k < 4) step();
    end
    checks++;
    if (bus3.sum !== 10'h060) begin
      errors++;
      $display("FAIL l3_sum: sum=%h, required 060", bus3.sum);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_reductions();
    test_basic_scan();
    test_write_during_scan();
    test_overflow();
    test_reset_mid_scan();
    test_back_to_back();
    test_lanes3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packed_bank_reduce.md
PACKED_BANK_REDUCE -- requirements
Module: packed_bank_reduce

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of packed lanes in the bank (legal range 2..64).
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per lane (legal range 1..32).
REQ-003 Derived widths: SW = WIDTH + $clog2(LANES) and LW = $clog2(LANES).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wr_en, input, 1 bit: lane write strobe.
REQ-007 Port wr_lane, input, LW bits: lane index to write.
REQ-008 Port wr_data, input, WIDTH bits: lane write data.
REQ-009 Port start, input, 1 bit: request to begin a sum scan.
REQ-010 Port busy, output, 1 bit: high while the scan is in the SCAN or DONE state.
REQ-011 Port done, output, 1 bit: one-cycle pulse marking that sum is valid.
REQ-012 Port sum, output, SW bits: result of the last completed scan.
REQ-013 Port sat, output, 1 bit: saturation flag (see Configuration).
REQ-014 Port bank, output, LANES*WIDTH bits: packed bank contents, lane i at bits [i*WIDTH +: WIDTH].
REQ-015 Ports red_or, red_and, red_xor and red_xnor, outputs, 1 bit each: registered reductions over the whole bank.

Function
REQ-016 Storage SHALL be a packed [LANES-1:0][WIDTH-1:0] register.
REQ-017 When wr_en=1, lane wr_lane SHALL take wr_data at the edge; the bank output SHALL reflect it in the next cycle.
REQ-018 Writes with wr_lane >= LANES SHALL be ignored.
REQ-019 The FSM SHALL have three states, IDLE, SCAN and DONE, with these transitions:
- IDLE to SCAN on start=1; at that edge, idx=0 and acc=0.
- SCAN: at each edge, acc += bank[idx] and idx++. The transition to DONE occurs on the edge that adds lane LANES-1.
- DONE to IDLE unconditionally after one cycle.
REQ-020 Timing of a scan:
- Start is accepted in cycle T.
- done=1 in cycle T+LANES+1 only.
- sum and sat SHALL update at the edge entering DONE and hold until the next scan completes.
REQ-021 start SHALL be ignored while busy=1; it is not queued.
REQ-022 A scan SHALL read each lane's value as registered in the cycle that lane is added.
- A same-cycle write to lane idx contributes the old value.
- A write to an already-scanned lane does not affect the sum.
REQ-023 Sum arithmetic SHALL be unsigned, zero-extended to SW bits, with no overflow when saturation is disabled.
REQ-024 Reductions SHALL be computed over all LANES*WIDTH bits of the bank and registered, giving 1-cycle latency after the bank changes.
REQ-025 red_xnor SHALL equal ~red_xor in every cycle.

Reset
REQ-026 On rst=1 at an edge, the following SHALL be cleared: the bank (all zero), the state (to IDLE), idx, acc, sum=0, sat=0, busy=0 and done=0.
REQ-027 The reduction outputs after reset SHALL be red_or=0, red_and=0, red_xor=0 and red_xnor=1.
REQ-028 rst SHALL have priority over wr_en and start in the same cycle.
REQ-029 rst asserted mid-scan SHALL abort the scan with no done pulse.

Configuration
REQ-030 Macro PACKED_BANK_REDUCE_SAT_EN SHALL select saturating summation.
REQ-031 With PACKED_BANK_REDUCE_SAT_EN defined:
- acc SHALL clamp at 2^WIDTH-1.
- sat SHALL be set if any addition in the scan would have exceeded the clamp.
- sum upper LW bits SHALL be zero.
REQ-032 Without PACKED_BANK_REDUCE_SAT_EN, the full SW-bit sum SHALL be produced and sat SHALL be tied to 0.

Verification (LANES=4, WIDTH=8)
REQ-033 Basic scan: write lanes 0..3 = 0x01, 0x04, 0x10, 0x40, then pulse start in cycle T -> done=1 exactly in cycle T+5, sum=0x055, sat=0, busy high T+1..T+5.
REQ-034 Reductions:
- All lanes 0x00 -> or=0, and=0, xor=0, xnor=1.
- Write lane 0 = 0x01 -> next cycle or=1, xor=1, xnor=0.
- All lanes 0xFF -> and=1, xor=0.
REQ-035 Write during scan: bank = 0x01, 0x04, 0x10, 0x40; in the start+1 cycle write lane 0 = 0x80 and in the start+2 cycle write lane 3 = 0x00 -> sum=0x015, and bank lane 0 = 0x80 after completion.
REQ-036 Overflow: all lanes 0xFF, then scan.
- Without the macro -> sum=0x3FC, sat=0.
- With PACKED_BANK_REDUCE_SAT_EN -> sum=0x0FF, sat=1.
REQ-037 Reset mid-scan: assert rst in cycle T+2 of a scan -> no done pulse, sum=0, and bank all zero; a subsequent start with lanes 0x01, 0x02, 0x03, 0x04 -> sum=0x00A.
REQ-038 Ignored inputs:
- start held high through a scan -> exactly one done per LANES+2 cycles, i.e. back-to-back scans with one IDLE cycle between.
- With LANES=3, a write with wr_lane=3 -> bank unchanged.
